// File: rtl/ofs_plat_prim_fifo_mc.sv
// Multi-channel FIFO: N_CHANNELS logical queues sharing one storage array, with a
// round-robin dequeue arbiter that holds its choice until the presented entry is consumed.
module ofs_plat_prim_fifo_mc #(
  parameter int N_DATA_BITS = 32,
  parameter int N_CHANNELS  = 4,
  parameter int N_ENTRIES   = 8,
  parameter int THRESHOLD   = 2,
  localparam int CW = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1,
  localparam int PW = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   reset_n,

  input  logic [N_DATA_BITS-1:0] enq_data,
  input  logic [CW-1:0]          enq_chan,
  input  logic                   enq_en,
  output logic [N_CHANNELS-1:0]  notFull,
  output logic [N_CHANNELS-1:0]  almostFull,

  output logic [N_DATA_BITS-1:0] first,
  output logic [CW-1:0]          first_chan,
  input  logic                   deq_en,
  output logic                   notEmpty,
  output logic [N_CHANNELS-1:0]  chan_notEmpty
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(N_ENTRIES);
  localparam logic [PW:0] THR_CNT  = (PW+1)'(THRESHOLD);

  logic [PW-1:0] wr_ptr_q [N_CHANNELS];
  logic [PW-1:0] wr_ptr_d [N_CHANNELS];
  logic [PW-1:0] rd_ptr_q [N_CHANNELS];
  logic [PW-1:0] rd_ptr_d [N_CHANNELS];
  logic [PW:0]   cnt_q    [N_CHANNELS];
  logic [PW:0]   cnt_d    [N_CHANNELS];

  logic [CW-1:0] rr_ptr_q, rr_ptr_d;
  logic [CW-1:0] hold_chan_q, hold_chan_d;
  logic          hold_q, hold_d;
  logic          rdy_q, rdy_d;

  logic [N_DATA_BITS-1:0] mem [2**(CW+PW)];

  logic [CW-1:0]         sel;
  logic                  found;
  logic                  chan_ok;
  logic                  enq_ok;
  logic                  deq_ok;
  logic [N_CHANNELS-1:0] enq_hit;
  logic [N_CHANNELS-1:0] deq_hit;

  // Channel index reached 'off' steps after 'base', wrapping at N_CHANNELS.
  function automatic logic [CW-1:0] rr_idx(input logic [CW-1:0] base, input int off);
    int j;
    j = int'(base) + off;
    if (j >= N_CHANNELS) j = j - N_CHANNELS;
    return CW'(j);
  endfunction

  generate
    if (N_CHANNELS == (1 << CW)) begin : g_chan_pow2
      assign chan_ok = 1'b1;
    end else begin : g_chan_range
      assign chan_ok = (enq_chan < CW'(N_CHANNELS));
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      chan_notEmpty[c] = (cnt_q[c] != '0);
      notFull[c]       = rdy_q && (cnt_q[c] != FULL_CNT);
      almostFull[c]    = !rdy_q || ((FULL_CNT - cnt_q[c]) <= THR_CNT);
    end
  end

  // A held channel is still non-empty: hold is only set while something is presented.
  always_comb begin
    sel   = rr_ptr_q;
    found = 1'b0;
    if (hold_q) begin
      sel = hold_chan_q;
    end else begin
      for (int i = 0; i < N_CHANNELS; i++) begin
        if (!found && (cnt_q[rr_idx(rr_ptr_q, i)] != '0)) begin
          sel   = rr_idx(rr_ptr_q, i);
          found = 1'b1;
        end
      end
    end
  end

  assign notEmpty   = |chan_notEmpty;
  assign first      = mem[{sel, rd_ptr_q[sel]}];
  assign first_chan = sel;

  assign enq_ok = enq_en && chan_ok && notFull[enq_chan];
  assign deq_ok = deq_en && notEmpty;

  always_comb begin
    for (int c = 0; c < N_CHANNELS; c++) begin
      enq_hit[c] = enq_ok && (enq_chan == CW'(c));
      deq_hit[c] = deq_ok && (sel == CW'(c));
    end
  end

  // NOTE: every always_comb output gets a default before any branch, so no latches infer.
  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    rr_ptr_d    = rr_ptr_q;
    hold_d      = notEmpty && !deq_en;
    hold_chan_d = sel;
    rdy_d       = 1'b1;

    for (int c = 0; c < N_CHANNELS; c++) begin
      if (enq_hit[c]) wr_ptr_d[c] = wr_ptr_q[c] + 1'b1;
      if (deq_hit[c]) rd_ptr_d[c] = rd_ptr_q[c] + 1'b1;
      case ({enq_hit[c], deq_hit[c]})
        2'b10:   cnt_d[c] = cnt_q[c] + 1'b1;
        2'b01:   cnt_d[c] = cnt_q[c] - 1'b1;
        default: cnt_d[c] = cnt_q[c];
      endcase
    end

    if (deq_ok) begin
      rr_ptr_d = (sel == CW'(N_CHANNELS - 1)) ? '0 : sel + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CHANNELS; c++) begin
        wr_ptr_q[c] <= '0;
        rd_ptr_q[c] <= '0;
        cnt_q[c]    <= '0;
      end
      rr_ptr_q    <= '0;
      hold_q      <= 1'b0;
      hold_chan_q <= '0;
      rdy_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_q      <= hold_d;
      hold_chan_q <= hold_chan_d;
      rdy_q       <= rdy_d;
    end
  end

  // NOTE: storage is deliberately left out of reset; occupancy counters gate every read.
  always_ff @(posedge clk) begin
    if (enq_ok) begin
      mem[{enq_chan, wr_ptr_q[enq_chan]}] <= enq_data;
    end
  end

  enq_legal_a: assert property (@(posedge clk) disable iff (!reset_n)
                                enq_en |-> (chan_ok && notFull[enq_chan]))
    else $fatal(1, "enqueue to full or out-of-range channel");

  deq_legal_a: assert property (@(posedge clk) disable iff (!reset_n)
                                deq_en |-> notEmpty)
    else $fatal(1, "dequeue while empty");

endmodule

// File: tb/tb_ofs_plat_prim_fifo_mc.sv
// Scoreboard bench for ofs_plat_prim_fifo_mc: expected (channel, data) pairs are queued
// in the order the arbiter must present them and compared as entries are dequeued.
module tb_ofs_plat_prim_fifo_mc;

  typedef struct packed {
    logic [1:0]  chan;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] enq_data = '0;
  logic [1:0]  enq_chan = '0;
  logic        enq_en = 1'b0;
  logic        deq_en = 1'b0;
  logic [3:0]  notFull, almostFull, chan_notEmpty;
  logic [31:0] first;
  logic [1:0]  first_chan;
  logic        notEmpty;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  ofs_plat_prim_fifo_mc #(
    .N_DATA_BITS(32), .N_CHANNELS(4), .N_ENTRIES(8), .THRESHOLD(2)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .enq_data(enq_data), .enq_chan(enq_chan), .enq_en(enq_en),
    .notFull(notFull), .almostFull(almostFull),
    .first(first), .first_chan(first_chan), .deq_en(deq_en),
    .notEmpty(notEmpty), .chan_notEmpty(chan_notEmpty)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] ch, input logic [31:0] d);
    exp_t e;
    e.chan = ch;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic enq(input logic [1:0] ch, input logic [31:0] d);
    enq_chan = ch;
    enq_data = d;
    enq_en   = 1'b1;
    tick();
    enq_en   = 1'b0;
  endtask

  task automatic peek_check(input string tag);
    check({tag, "_notEmpty"}, 64'(notEmpty), 64'd1);
    if (exp_q.size() == 0) begin
      check({tag, "_sb_underflow"}, 64'd0, 64'd1);
    end else begin
      check({tag, "_chan"}, 64'(first_chan), 64'(exp_q[0].chan));
      check({tag, "_data"}, 64'(first), 64'(exp_q[0].data));
    end
  endtask

  task automatic deq_check(input string tag);
    peek_check(tag);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    deq_en = notEmpty;
    tick();
    deq_en = 1'b0;
  endtask

  task automatic enq_deq_check(input string tag, input logic [1:0] ch, input logic [31:0] d);
    peek_check(tag);
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    push(ch, d);
    enq_chan = ch;
    enq_data = d;
    enq_en   = 1'b1;
    deq_en   = notEmpty;
    tick();
    enq_en   = 1'b0;
    deq_en   = 1'b0;
  endtask

  initial begin
    // Reset and the one-cycle rdy delay after release.
    tick();
    check("rst_notFull", 64'(notFull), 64'h0);
    check("rst_almostFull", 64'(almostFull), 64'hF);
    check("rst_notEmpty", 64'(notEmpty), 64'd0);
    check("rst_first_chan", 64'(first_chan), 64'd0);
    reset_n = 1'b1;
    #1;
    check("rel_notFull_gated", 64'(notFull), 64'h0);
    tick();
    check("rdy_notFull", 64'(notFull), 64'hF);
    check("rdy_almostFull", 64'(almostFull), 64'h0);

    // Fill channel 2 to the top, watching the flag thresholds.
    for (int i = 0; i < 8; i++) begin
      push(2'd2, 32'h20 + 32'(i));
      enq(2'd2, 32'h20 + 32'(i));
      check($sformatf("fill_af_%0d", i + 1), 64'(almostFull), (i >= 5) ? 64'h4 : 64'h0);
      check($sformatf("fill_nf_%0d", i + 1), 64'(notFull), (i == 7) ? 64'hB : 64'hF);
    end
    check("fill_chan_ne", 64'(chan_notEmpty), 64'h4);
    for (int i = 0; i < 8; i++) deq_check($sformatf("drain_%0d", i));
    check("drain_notEmpty", 64'(notEmpty), 64'd0);
    check("drain_notFull", 64'(notFull), 64'hF);

    // Round-robin across channels 0, 1 and 3.
    push(2'd0, 32'hA0); push(2'd1, 32'hB0); push(2'd3, 32'hC0); push(2'd0, 32'hA1);
    enq(2'd0, 32'hA0);
    enq(2'd1, 32'hB0);
    enq(2'd3, 32'hC0);
    enq(2'd0, 32'hA1);
    for (int i = 0; i < 4; i++) deq_check($sformatf("rr_%0d", i));

    // Hold: the presented entry must not change until dequeued.
    push(2'd1, 32'h11);
    enq(2'd1, 32'h11);
    push(2'd0, 32'h00);
    enq(2'd0, 32'h00);
    for (int i = 0; i < 3; i++) begin
      peek_check($sformatf("hold1_%0d", i));
      tick();
    end
    deq_check("hold1_deq");
    tick();
    push(2'd3, 32'h33);
    enq(2'd3, 32'h33);
    for (int i = 0; i < 3; i++) begin
      peek_check($sformatf("hold0_%0d", i));
      tick();
    end
    deq_check("hold0_deq");
    deq_check("hold3_deq");
    check("hold_empty", 64'(notEmpty), 64'd0);

    // Pointer wrap with concurrent enqueue and dequeue on channel 0.
    for (int i = 0; i < 3; i++) begin
      push(2'd0, 32'h50 + 32'(i));
      enq(2'd0, 32'h50 + 32'(i));
    end
    for (int i = 0; i < 20; i++) begin
      enq_deq_check($sformatf("wrap_%0d", i), 2'd0, 32'h53 + 32'(i));
      check($sformatf("wrap_nf_%0d", i), 64'(notFull), 64'hF);
      check($sformatf("wrap_af_%0d", i), 64'(almostFull), 64'h0);
      check($sformatf("wrap_ne_%0d", i), 64'(chan_notEmpty), 64'h1);
    end
    for (int i = 0; i < 3; i++) deq_check($sformatf("wrap_drain_%0d", i));
    check("wrap_empty", 64'(notEmpty), 64'd0);
    check("wrap_sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset between clock edges with traffic in three channels.
    enq(2'd0, 32'h60);
    enq(2'd1, 32'h61);
    enq(2'd2, 32'h62);
    check("pre_arst_chan_ne", 64'(chan_notEmpty), 64'h7);
    #3 reset_n = 1'b0;
    #1;
    check("arst_notEmpty", 64'(notEmpty), 64'd0);
    check("arst_chan_ne", 64'(chan_notEmpty), 64'h0);
    check("arst_notFull", 64'(notFull), 64'h0);
    check("arst_almostFull", 64'(almostFull), 64'hF);
    exp_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    check("post_arst_chan_ne", 64'(chan_notEmpty), 64'h0);
    check("post_arst_notFull", 64'(notFull), 64'hF);
    push(2'd3, 32'h77);
    enq(2'd3, 32'h77);
    deq_check("post_arst_deq");
    check("post_arst_empty", 64'(notEmpty), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
